// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops words from a synchronous FIFO (registered read
// data, one-cycle latency) into a 2-entry in-order skid buffer and presents
// them as a valid/ready stream. Counts delivered words.
module fifo_stream_reader #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       fifo_empty,
  output logic                       fifo_read,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_read_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIFO_DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]       word_count,
  output logic                       busy
);

  logic [1:0]                 occ_q, occ_d;
  logic                       pend_q;
  logic                       valid_q, valid_d;
  logic [FIFO_DATA_WIDTH-1:0] head_q, head_d;
  logic [FIFO_DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

  logic                       hs_s;
  logic [1:0]                 inflight_s;
  logic [1:0]                 occ_pop_s;

  // Issue a pop only when a slot is guaranteed free by the time its data lands.
  always_comb begin
    hs_s       = valid_q & out_ready;
    inflight_s = occ_q + {1'b0, pend_q};
    fifo_read  = reset_n & enable & ~fifo_empty &
                 ((inflight_s <= 2'd1) | ((inflight_s == 2'd2) & hs_s));
  end

  // Buffer next state: pop on handshake first, then place the landing word
  // into the first free slot so order is preserved.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    occ_pop_s = occ_q;
    cnt_d     = cnt_q;
    if (hs_s) begin
      head_d    = tail_q;
      occ_pop_s = occ_q - 2'd1;
      cnt_d     = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      occ_pop_s = occ_q;
    end
    if (pend_q) begin
      if (occ_pop_s == 2'd0) begin
        head_d = fifo_read_data;
      end else begin
        tail_d = fifo_read_data;
      end
    end else begin
      tail_d = tail_d;
    end
    occ_d   = occ_pop_s + {1'b0, pend_q};
    valid_d = (occ_d != 2'd0);
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= 2'd0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      head_q  <= {FIFO_DATA_WIDTH{1'b0}};
      tail_q  <= {FIFO_DATA_WIDTH{1'b0}};
      cnt_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      occ_q   <= occ_d;
      pend_q  <= fifo_read;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = head_q;
  assign word_count = cnt_q;
  assign busy       = valid_q | pend_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO with registered read data,
// scoreboard of expected words, a second instance with a 4-bit counter.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_read, fifo_read4;
  logic [7:0]  fifo_read_data;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [7:0]  out_data, out_data4;
  logic [15:0] word_count;
  logic [3:0]  word_count4;
  logic        busy, busy4;

  fifo_stream_reader #(.FIFO_DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .fifo_read_data(fifo_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .word_count(word_count), .busy(busy)
  );

  fifo_stream_reader #(.FIFO_DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read4), .fifo_read_data(fifo_read_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .word_count(word_count4), .busy(busy4)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int delivered = 0;

  logic       rd_s, hs_s, busy_s, vld_s;
  logic [7:0] dat_s;
  logic [15:0] cnt_s;
  logic [3:0] cnt4_s;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
  endtask

  // One clock cycle, entered and left at a falling edge with inputs set.
  task automatic step();
    logic [7:0] nd;
    nd = 8'h00;
    fifo_empty = (fifo_q.size() == 0);
    #1;
    rd_s   = fifo_read;
    hs_s   = out_valid & out_ready;
    busy_s = busy;
    vld_s  = out_valid;
    dat_s  = out_data;
    cnt_s  = word_count;
    cnt4_s = word_count4;
    if (hs_s) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_nonempty", exp_q.size(), 1);
      end else begin
        check_eq("data", out_data, exp_q.pop_front());
      end
      delivered++;
    end
    if (rd_s) begin
      if (fifo_q.size() == 0) check_eq("fifo_underflow", fifo_q.size(), 1);
      else nd = fifo_q.pop_front();
    end
    @(posedge clk);
    #1;
    if (rd_s) fifo_read_data = nd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", word_count, 0);
    check_eq("rst_count4", word_count4, 0);
    check_eq("rst_read", fifo_read, 0);
    check_eq("rst_data", out_data, 0);
    fifo_q.delete();
    exp_q.delete();
    delivered = 0;
    fifo_read_data = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int rd_cnt;
    int hs_cnt;
    reset_n = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    fifo_empty = 1'b0;
    fifo_read_data = 8'h00;
    @(negedge clk);
    do_reset();

    // Three preloaded words: reads cycles 0-2, delivery cycles 2-4.
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("t1_rd%0d", i), rd_s, (i < 3) ? 1 : 0);
      check_eq($sformatf("t1_hs%0d", i), hs_s, (i >= 2 && i <= 4) ? 1 : 0);
    end
    check_eq("t1_busy", busy_s, 0);
    check_eq("t1_count", cnt_s, 3);

    // Backpressure: only two pops, head word held stable.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'h40 + i[7:0]);
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rd_s) rd_cnt++;
      if (i >= 2) begin
        check_eq("t2_hold_valid", vld_s, 1);
        check_eq("t2_hold_data", dat_s, 8'h40);
      end
    end
    check_eq("t2_reads", rd_cnt, 2);
    out_ready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("t2_stream", hs_s, 1);
      if (hs_s) hs_cnt++;
    end
    check_eq("t2_delivered", hs_cnt, 10);
    step();
    check_eq("t2_busy", busy_s, 0);
    check_eq("t2_count", cnt_s, 10);

    // Toggling ready with a continuously refilled FIFO, 100 words.
    do_reset();
    begin
      int pushed = 0;
      for (int c = 0; c < 1000 && delivered < 100; c++) begin
        while (pushed < 100 && fifo_q.size() < 3) begin
          push_word(8'(pushed * 7 + 3));
          pushed++;
        end
        out_ready = (c % 2 == 0);
        step();
      end
    end
    check_eq("t3_delivered", delivered, 100);
    out_ready = 1'b1;
    step();
    check_eq("t3_count", cnt_s, 100);
    check_eq("t3_count4", cnt4_s, 4);
    check_eq("t3_sb_left", exp_q.size(), 0);

    // Enable dropped right after a read: in-flight word still delivered.
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'hA0 + i[7:0]);
    step();
    check_eq("t4_first_rd", rd_s, 1);
    enable = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rd_s) rd_cnt++;
    end
    check_eq("t4_no_rd", rd_cnt, 0);
    check_eq("t4_delivered", delivered, 1);
    check_eq("t4_busy", busy_s, 0);
    check_eq("t4_fifo_left", fifo_q.size(), 4);
    enable = 1'b1;

    // Reset asserted with a full buffer takes effect without a clock edge.
    do_reset();
    for (int i = 0; i < 6; i++) push_word(8'h60 + i[7:0]);
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) step();
    check_eq("t5_pre_valid", vld_s, 1);
    check_eq("t5_pre_count", cnt_s, 1);
    #2;
    do_reset();
    out_ready = 1'b1;

    // 17 words: 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) push_word(8'hC0 + i[7:0]);
    for (int c = 0; c < 100 && delivered < 17; c++) step();
    check_eq("t6_delivered", delivered, 17);
    step();
    check_eq("t6_count", cnt_s, 17);
    check_eq("t6_count4", cnt4_s, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
